cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor-0 register file and exception-state machine for the 54-instruction pipelined MIPS CPU.
- Consumes the decoder's CP0 command strobes (mfc0, mtc0, eret, exception, cause, cp0_addr).
- Returns the Status word the decoder uses to qualify syscall/break/teq traps.
- Supplies the PC-redirect targets (EPC for eret, handler address for exceptions) and a free-running Count/Compare timer interrupt.

Parameters:
HANDLER_ADDR, 32'h00400004, PC loaded on any exception (driven on exc_addr)
STATUS_RESET, 32'h0000000F, Status reset value (IE=1, syscall/break/teq enabled, timer disabled)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  pipeline-advance qualifier; mtc0/eret/exception take effect only when high
mfc0  in  1  read command from decoder
mtc0  in  1  write command from decoder
eret  in  1  return-from-exception command
exception  in  1  trap/interrupt accepted this cycle
cause  in  5  ExcCode of the trap (0 = interrupt, 8 = syscall, 9 = break, 13 = teq)
cp0_addr  in  5  CP0 register number (instruction[15:11])
wdata  in  32  rt value for mtc0
pc  in  32  address of the excepting instruction
rdata  out  32  mfc0 read data
status  out  32  current Status register
epc_out  out  32  current EPC (eret target)
exc_addr  out  32  exception handler address = HANDLER_ADDR
timer_irq  out  1  timer interrupt request

Behaviour:
- Implemented registers:
  - Count (9), Compare (11), Status (12), Cause (13), EPC (14).
  - Other addresses: reads return 0, writes are ignored.
- Reset (async, rst_n=0):
  - Count=0, Compare=0, Cause=0, EPC=0, Status=STATUS_RESET.
  - Outputs during reset: status=STATUS_RESET, epc_out=0, timer_irq=0, rdata=0.
  - Reset mid-operation aborts any update; no partial writes.
- rdata is combinational:
  - mfc0=1: value of register cp0_addr as held before this edge (no same-cycle mtc0 bypass).
  - mfc0=0: rdata=0.
- mtc0 (ena=1): register cp0_addr <= wdata at the edge, 1-cycle latency.
  - Writing Cause updates only bits [9:8] (software IP); all other Cause bits are read-only.
- Exception entry (ena=1, exception=1):
  - Status <= {Status[26:0], 5'b0} (masks nest).
  - Cause[6:2] <= cause.
  - EPC <= pc.
- eret (ena=1, eret=1, exception=0): Status <= {5'b0, Status[31:5]}. EPC and Cause are unchanged.
- Same-cycle priority: exception > eret > mtc0. A lower-priority command in the same cycle is dropped entirely.
- Count:
  - Increments by 1 every cycle regardless of ena; wraps 32'hFFFFFFFF -> 0.
  - An mtc0 to Count loads wdata instead of incrementing that cycle.
- Timer pending bit Cause[15]:
  - Set on the edge where the pre-edge Count == Compare and Compare != 0.
  - Cleared by mtc0 to Compare. If set and clear coincide, clear wins.
  - Unaffected by exception/eret.
- timer_irq = Status[0] & Status[4] & Cause[15], combinational from registers. It therefore asserts one cycle after the match edge.
- epc_out and exc_addr are continuous, so the PC mux can redirect in the same cycle the eret/exception is decoded.
- ena=0: no architectural change other than Count increment and the Cause[15] set rule.

Test Plan:
- Reset then idle 3 cycles -> status=32'h0000000F, epc_out=0, timer_irq=0; mfc0 addr 9 reads 2 one cycle after the first post-reset edge sequence (Count counting from 0).
- mtc0 addr 14 wdata=32'h00400100, next cycle mfc0 addr 14 -> rdata=32'h00400100. mtc0 addr 20 wdata=5 then mfc0 addr 20 -> 0.
- exception with cause=8, pc=32'h00400020, Status=32'h0000000F -> next cycle status=32'h000001E0, Cause[6:2]=8, epc_out=32'h00400020, exc_addr=32'h00400004. Following eret -> status=32'h0000000F.
- Simultaneous exception (cause=9) and eret with ena=1 -> exception wins: Status shifted left 5, Cause[6:2]=9. Same pair with ena=0 -> no change.
- Timer path:
  - Write Status=32'h00000011, Compare=20, Count=18 -> Cause[15] sets when Count passes 20; timer_irq=1 one cycle later.
  - mtc0 Compare=100 -> timer_irq=0 next cycle.
  - Count=32'hFFFFFFFF wraps to 0.
- Assert rst_n=0 asynchronously mid-cycle during an exception -> outputs return to reset values immediately, before the next clock edge; EPC not written.

Source files
------------

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC,
// exception entry/return sequencing and PC redirect targets.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
    parameter logic [31:0] STATUS_RESET = 32'h0000000F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic        eret,
    input  logic        exception,
    input  logic [4:0]  cause,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] epc_out,
    output logic [31:0] exc_addr,
    output logic        timer_irq
);

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;
    localparam logic [4:0] A_EPC     = 5'd14;

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic [31:0] cause_nxt;

    logic exc_go;
    logic eret_go;
    logic wr_go;
    logic timer_hit;
    logic cmp_wr;

    // exception > eret > mtc0; the loser is dropped entirely
    assign exc_go    = ena & exception;
    assign eret_go   = ena & eret & ~exception;
    assign wr_go     = ena & mtc0 & ~exception & ~eret;
    assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);
    assign cmp_wr    = wr_go && (cp0_addr == A_COMPARE);

    always_comb begin
        cause_nxt = cause_q;
        if (exc_go)
            cause_nxt[6:2] = cause;
        if (wr_go && (cp0_addr == A_CAUSE))
            cause_nxt[9:8] = wdata[9:8];
        if (timer_hit)
            cause_nxt[15] = 1'b1;
        if (cmp_wr)
            cause_nxt[15] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= STATUS_RESET;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
        end else begin
            if (wr_go && (cp0_addr == A_COUNT))
                count_q <= wdata;
            else
                count_q <= count_q + 32'd1;

            if (cmp_wr)
                compare_q <= wdata;

            if (exc_go)
                status_q <= {status_q[26:0], 5'b0};
            else if (eret_go)
                status_q <= {5'b0, status_q[31:5]};
            else if (wr_go && (cp0_addr == A_STATUS))
                status_q <= wdata;

            if (exc_go)
                epc_q <= pc;
            else if (wr_go && (cp0_addr == A_EPC))
                epc_q <= wdata;

            cause_q <= cause_nxt;
        end
    end

    // read data is forced low while reset is held
    always_comb begin
        rdata = 32'd0;
        if (mfc0 && rst_n) begin
            case (cp0_addr)
                A_COUNT:   rdata = count_q;
                A_COMPARE: rdata = compare_q;
                A_STATUS:  rdata = status_q;
                A_CAUSE:   rdata = cause_q;
                A_EPC:     rdata = epc_q;
                default:   rdata = 32'd0;
            endcase
        end
    end

    assign status    = status_q;
    assign epc_out   = epc_q;
    assign exc_addr  = HANDLER_ADDR;
    assign timer_irq = status_q[0] & status_q[4] & cause_q[15];

endmodule
